// File: rtl/fifo_uart_defs.sv
// fifo_uart_defs: shared definitions for the FIFO-draining UART transmitter.
//   - 3-bit state encodings and the matching enum type
//   - parity mode constants
//   - default bit period in clock cycles
package fifo_uart_defs;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_POP   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_PAR   = 3'd5;
  localparam logic [2:0] ST_STOP  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    POP   = ST_POP,
    WAIT  = ST_WAIT,
    START = ST_START,
    DATA  = ST_DATA,
    PAR   = ST_PAR,
    STOP  = ST_STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// baud_tick: bit-period down-counter.
//   clk      in  system clock
//   rst      in  async active-low reset
//   clr      in  restart the bit period (driven on FSM state entry)
//   tick     out high in the last cycle of each bit period
//   pre_tick out high in the cycle before the last one (lets the FSM
//                register outputs that must line up with the last cycle)
module baud_tick
  import fifo_uart_defs::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (clr || cnt_q == '0) cnt_d = TOP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= TOP;
    else      cnt_q <= cnt_d;
  end

  assign tick     = (cnt_q == '0);
  assign pre_tick = (cnt_q == CW'(1));

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO and serializes each byte, LSB first,
// as start / DATA_W data / optional parity / stop.
//   clk, rst     clock, async active-low reset
//   tx_en        allow fetching a new byte (looked at only while idle)
//   fifo_empty   FIFO empty flag
//   fifo_data    FIFO read data (valid the cycle after the pop)
//   fifo_rd_en   one-cycle pop strobe
//   tx           serial line, idle high
//   busy         not idle
//   tx_done      pulse in the final stop-bit cycle
//   bytes_sent   completed frame count, wrapping
// All outputs are flops loaded from the next-state decode, so each output
// changes on the same edge as the state it belongs to.
module fifo_uart_tx
  import fifo_uart_defs::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic [15:0]       bytes_sent
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       sent_q, sent_d;
  logic              clr, tick, pre_tick;

  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    sent_d    = sent_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE:  if (tx_en && !fifo_empty) state_d = POP;
      POP:   state_d = WAIT;
      WAIT: begin
        // Byte and its parity are captured here; later FIFO activity
        // cannot disturb the frame.
        shift_d   = fifo_data;
        bit_cnt_d = '0;
        par_d     = (^fifo_data) ^ (PARITY == PARITY_ODD);
        state_d   = START;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == LAST_BIT)
          state_d = (PARITY != PARITY_NONE) ? PAR : STOP;
      end
      PAR:   if (tick) state_d = STOP;
      STOP: begin
        // Registered one cycle early so the pulse and count update land
        // in the final stop-bit cycle.
        if (pre_tick) begin
          done_d = 1'b1;
          sent_d = sent_q + 16'd1;
        end
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    clr = (state_d != state_q);

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    rd_d   = (state_d == POP);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sent_q    <= sent_d;
    end
  end

  assign fifo_rd_en = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign bytes_sent = sent_q;

endmodule
